// File: rtl/ddr_pixel_fetch_pkg.sv
// Shared definitions for the DDR pixel fetch path: FSM state encoding,
// frame geometry and default parameter values. The display timing logic
// reuses the same geometry constants.
package ddr_pixel_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam int H_ACTIVE        = 640;
    localparam int V_ACTIVE        = 480;
    localparam int PIXEL_BITS      = 16;
    localparam int WORD_BITS       = 32;

    localparam int FRAME_WORDS_DEF = H_ACTIVE * V_ACTIVE * PIXEL_BITS / WORD_BITS;
    localparam int ADDR_W_DEF      = 18;
    localparam int BASE_ADDR_DEF   = 0;
    localparam int FIFO_DEPTH_DEF  = 16;

    // First pixel lives in the low half of each word.
    function automatic logic [15:0] select_half(input logic [31:0] word, input logic hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/ddr_word_fifo.sv
// Single-clock word FIFO with occupancy count, synchronous flush and
// first-word-fall-through head output. A write while full is accepted
// when a read happens in the same cycle.
module ddr_word_fifo
    import ddr_pixel_fetch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic                     rd_en_i,
    output logic [W-1:0]             rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_wr;
    logic          do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_rd   = rd_en_i & ~empty_o;
    assign do_wr   = wr_en_i & (~full_o | do_rd) & ~flush_i;

    // Head word is read combinationally so it is visible the cycle after the write.
    assign rd_data_o = mem[rd_ptr_q];
    assign count_o   = count_q;

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/ddr_pixel_fetch.sv
// Read-side frame fetcher: issues sequential word reads to the DDR
// controller under a credit limit, buffers returns in ddr_word_fifo and
// unpacks each word into two 16-bit pixels for scan-out.
// Optional macro UNDERFLOW_HOLD_EN: while a frame is active and the FIFO is
// empty, keep pixelValid high and repeat the last transferred pixel.
module ddr_pixel_fetch
    import ddr_pixel_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int BASE_ADDR   = BASE_ADDR_DEF
) (
    input  logic              clk133_p,
    input  logic              rst,
    input  logic              frameStart,
    output logic              reqValid,
    output logic [ADDR_W-1:0] reqAddr,
    input  logic              reqReady,
    input  logic              rdValid,
    input  logic [31:0]       rdData,
    output logic              pixelValid,
    output logic [15:0]       pixel,
    input  logic              pixelReady,
    output logic              busy,
    output logic              overflowErr,
    output logic              underflowErr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = $clog2(FRAME_WORDS + 1);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RW-1:0]     req_cnt_q;
    logic [CW-1:0]     outst_q;
    logic [CW-1:0]     outst_d;
    logic [CW-1:0]     discard_q;
    logic              half_q;
    logic              ovf_q;
    logic              udf_q;

    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [31:0]       fifo_head;
    logic              fifo_wr;
    logic              fifo_pop;

    logic              active;
    logic              credit_ok;
    logic              req_valid_c;
    logic              req_xfer;
    logic              abort;
    logic              rd_accept;
    logic              rd_keep;
    logic              pix_real;
    logic              ovf_event;
    logic              udf_event;
    logic              pixel_valid_c;
    logic [15:0]       pixel_c;

`ifdef UNDERFLOW_HOLD_EN
    logic [15:0]       last_pix_q;
`endif

    assign active      = (state_q != ST_IDLE);
    // Every word in flight or buffered holds a FIFO slot, so returns can never overflow.
    assign credit_ok   = ({1'b0, outst_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign req_valid_c = (state_q == ST_FETCH) & credit_ok & (discard_q == '0);
    assign req_xfer    = req_valid_c & reqReady;
    assign abort       = frameStart & active;

    // Returns with nothing outstanding are stray and never reach the FIFO.
    assign rd_accept   = rdValid & (outst_q != '0);
    assign rd_keep     = rd_accept & (discard_q == '0) & ~abort;
    assign pix_real    = pixelReady & ~fifo_empty;
    assign fifo_pop    = pix_real & half_q;
    assign fifo_wr     = rd_keep & (~fifo_full | fifo_pop);

    assign ovf_event   = (rdValid & (outst_q == '0)) | (rd_keep & fifo_full & ~fifo_pop);
    assign udf_event   = pixelReady & fifo_empty & active;

    assign outst_d     = outst_q + CW'(req_xfer) - CW'(rd_accept);

    // Pixel presented straight from the FIFO head, or held while starved.
    always_comb begin
        pixel_valid_c = ~fifo_empty;
        pixel_c       = fifo_empty ? 16'h0000 : select_half(fifo_head, half_q);
`ifdef UNDERFLOW_HOLD_EN
        if (fifo_empty && active) begin
            pixel_valid_c = 1'b1;
            pixel_c       = last_pix_q;
        end
`endif
    end

    ddr_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk       (clk133_p),
        .rst       (rst),
        .flush_i   (abort),
        .wr_en_i   (fifo_wr),
        .wr_data_i (rdData),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_head),
        .count_o   (fifo_count),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    // Frame FSM with request address/count, credits, discard counter and half select.
    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= BASE;
            req_cnt_q <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            half_q    <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            ovf_q   <= ovf_q | ovf_event;
            udf_q   <= udf_q | udf_event;
            outst_q <= outst_d;

            if (pix_real) begin
                half_q <= ~half_q;
            end
            if ((discard_q != '0) && rd_accept) begin
                discard_q <= discard_q - 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (frameStart) begin
                        state_q   <= ST_FETCH;
                        addr_q    <= BASE;
                        req_cnt_q <= '0;
                        half_q    <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (req_xfer) begin
                        addr_q    <= addr_q + 1'b1;
                        req_cnt_q <= req_cnt_q + 1'b1;
                        if (req_cnt_q == RW'(FRAME_WORDS - 1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((outst_q == '0) && fifo_empty) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Restart: words still in flight belong to the old frame and are dropped.
            if (abort) begin
                state_q   <= ST_FETCH;
                addr_q    <= BASE;
                req_cnt_q <= '0;
                half_q    <= 1'b0;
                discard_q <= outst_d;
            end
        end
    end

`ifdef UNDERFLOW_HOLD_EN
    // Remember the last real pixel so a starved consumer can keep repeating it.
    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            last_pix_q <= 16'h0000;
        end else if (frameStart) begin
            last_pix_q <= 16'h0000;
        end else if (pix_real) begin
            last_pix_q <= pixel_c;
        end
    end
`endif

    assign reqValid     = req_valid_c;
    assign reqAddr      = addr_q;
    assign pixelValid   = pixel_valid_c;
    assign pixel        = pixel_c;
    assign busy         = active;
    assign overflowErr  = ovf_q;
    assign underflowErr = udf_q;

endmodule

// File: tb/tb_ddr_pixel_fetch.sv
// Directed bench for ddr_pixel_fetch: a cycle table for the credit/unpack
// path plus hand sequences for abort, stray returns and a short frame.
module tb_ddr_pixel_fetch;

`ifdef UNDERFLOW_HOLD_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fs, rr, rv, pr;
    logic [31:0] rdata;
    logic        req_valid, pix_valid, busy, oe, ue;
    logic [17:0] req_addr;
    logic [15:0] pix;

    logic        fs4, rr4, rv4, pr4;
    logic [31:0] rdata4;
    logic        req_valid4, pix_valid4, busy4, oe4, ue4;
    logic [17:0] req_addr4;
    logic [15:0] pix4;

    ddr_pixel_fetch dut (
        .clk133_p(clk), .rst(rst), .frameStart(fs),
        .reqValid(req_valid), .reqAddr(req_addr), .reqReady(rr),
        .rdValid(rv), .rdData(rdata),
        .pixelValid(pix_valid), .pixel(pix), .pixelReady(pr),
        .busy(busy), .overflowErr(oe), .underflowErr(ue)
    );

    ddr_pixel_fetch #(.FRAME_WORDS(4)) dut4 (
        .clk133_p(clk), .rst(rst), .frameStart(fs4),
        .reqValid(req_valid4), .reqAddr(req_addr4), .reqReady(rr4),
        .rdValid(rv4), .rdData(rdata4),
        .pixelValid(pix_valid4), .pixel(pix4), .pixelReady(pr4),
        .busy(busy4), .overflowErr(oe4), .underflowErr(ue4)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        fs, rr, rv, pr;
        logic [31:0] rd;
        logic        e_rv;
        logic [17:0] e_addr;
        logic        e_pv;
        logic [15:0] e_px;
        logic        e_busy;
        logic        e_ue;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    task automatic row(input int i, input logic f, input logic r, input logic v,
                       input logic [31:0] d, input logic p, input logic erv,
                       input logic [17:0] ea, input logic epv, input logic [15:0] epx,
                       input logic eb, input logic eu);
        tbl[i].fs = f;  tbl[i].rr = r;  tbl[i].rv = v;  tbl[i].rd = d;  tbl[i].pr = p;
        tbl[i].e_rv = erv; tbl[i].e_addr = ea; tbl[i].e_pv = epv; tbl[i].e_px = epx;
        tbl[i].e_busy = eb; tbl[i].e_ue = eu;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fs = 0; rr = 0; rv = 0; pr = 0; rdata = '0;
        fs4 = 0; rr4 = 0; rv4 = 0; pr4 = 0; rdata4 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nreq, npix, bad_addr, cyc;
        logic        prev_req;
        logic [17:0] prev_addr;
        logic [15:0] hold_px;

        hold_px = HOLD ? 16'h2222 : 16'h0000;

        // Credit fill, first return, unpack, pop-frees-credit, underflow.
        row(0,  1,1,0,32'h0,        0, 0, 18'd0,  0,    16'h0,    0, 0);
        row(1,  0,1,0,32'h0,        0, 1, 18'd0,  HOLD, 16'h0,    1, 0);
        row(2,  0,1,1,32'h22221111, 0, 1, 18'd1,  HOLD, 16'h0,    1, 0);
        for (int k = 3; k <= 16; k++)
            row(k, 0,1,0,32'h0, 0, 1, 18'(k - 1), 1, 16'h1111, 1, 0);
        row(17, 0,1,0,32'h0,        1, 0, 18'd16, 1,    16'h1111, 1, 0);
        row(18, 0,1,0,32'h0,        1, 0, 18'd16, 1,    16'h2222, 1, 0);
        row(19, 0,1,0,32'h0,        0, 1, 18'd16, HOLD, hold_px,  1, 0);
        row(20, 0,1,0,32'h0,        1, 0, 18'd17, HOLD, hold_px,  1, 0);
        row(21, 0,0,0,32'h0,        0, 0, 18'd17, HOLD, hold_px,  1, 1);

        rst = 1'b1;
        do_reset();

        // Reset values.
        @(negedge clk);
        chk("rst_reqValid", 32'(req_valid), 32'd0);
        chk("rst_reqAddr", 32'(req_addr), 32'd0);
        chk("rst_pixelValid", 32'(pix_valid), 32'd0);
        chk("rst_pixel", 32'(pix), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflowErr", 32'(oe), 32'd0);
        chk("rst_underflowErr", 32'(ue), 32'd0);

        // Credit limit with no returns: exactly FIFO_DEPTH requests.
        fs = 1; rr = 1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            fs = 0;
            if (req_valid) begin
                chk("t1_req_addr", 32'(req_addr), 32'(n));
                n++;
            end
        end
        chk("t1_req_count", 32'(n), 32'd16);
        chk("t1_reqValid_blocked", 32'(req_valid), 32'd0);

        // Table-driven cycle sequence.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_reqValid", i), 32'(req_valid), 32'(tbl[i].e_rv));
            chk($sformatf("v%0d_reqAddr", i), 32'(req_addr), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d_pixelValid", i), 32'(pix_valid), 32'(tbl[i].e_pv));
            if (tbl[i].e_pv || i == 0)
                chk($sformatf("v%0d_pixel", i), 32'(pix), 32'(tbl[i].e_px));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d_underflowErr", i), 32'(ue), 32'(tbl[i].e_ue));
            fs = tbl[i].fs; rr = tbl[i].rr; rv = tbl[i].rv; rdata = tbl[i].rd; pr = tbl[i].pr;
        end
        fs = 0; rr = 0; rv = 0; pr = 0; rdata = '0;

        // Abort with 5 words in flight.
        do_reset();
        @(negedge clk);
        fs = 1; rr = 1;
        @(negedge clk);
        fs = 0;
        for (int k = 0; k < 5; k++) begin
            chk("t4_req_addr", 32'(req_addr), 32'(k));
            @(negedge clk);
        end
        rr = 0;
        chk("t4_addr_held0", 32'(req_addr), 32'd5);
        @(negedge clk);
        chk("t4_addr_held1", 32'(req_addr), 32'd5);
        chk("t4_reqValid_held", 32'(req_valid), 32'd1);
        fs = 1;
        @(negedge clk);
        fs = 0;
        for (int k = 0; k < 5; k++) begin
            chk("t4_discard_reqValid", 32'(req_valid), 32'd0);
            chk("t4_discard_pixelValid", 32'(pix_valid), 32'(HOLD));
            rv = 1; rdata = 32'hDEAD_0000 + 32'(k);
            @(negedge clk);
        end
        rv = 0; rdata = '0;
        chk("t4_after_pixelValid", 32'(pix_valid), 32'(HOLD));
        chk("t4_restart_reqValid", 32'(req_valid), 32'd1);
        chk("t4_restart_addr", 32'(req_addr), 32'd0);
        rr = 1;
        @(negedge clk);
        rr = 0; rv = 1; rdata = 32'hBBBB_AAAA;
        @(negedge clk);
        rv = 0; rdata = '0;
        chk("t4_new_pixelValid", 32'(pix_valid), 32'd1);
        chk("t4_new_pixel", 32'(pix), 32'h0000AAAA);
        chk("t4_overflowErr", 32'(oe), 32'd0);

        // Stray return with nothing outstanding.
        do_reset();
        @(negedge clk);
        rv = 1; rdata = 32'h1234_5678;
        @(negedge clk);
        rv = 0; rdata = '0;
        chk("t5_overflowErr_set", 32'(oe), 32'd1);
        chk("t5_pixelValid", 32'(pix_valid), 32'd0);
        repeat (3) @(negedge clk);
        fs = 1;
        @(negedge clk);
        fs = 0;
        repeat (2) @(negedge clk);
        chk("t5_overflowErr_sticky", 32'(oe), 32'd1);
        do_reset();
        @(negedge clk);
        chk("t5_overflowErr_cleared", 32'(oe), 32'd0);

        // Short frame on the 4-word instance.
        @(negedge clk);
        fs4 = 1; rr4 = 1; pr4 = 1;
        @(negedge clk);
        fs4 = 0;
        prev_req = 0; prev_addr = '0;
        nreq = 0; npix = 0; bad_addr = 0; cyc = 0;
        while (cyc < 60) begin
            rv4    = prev_req;
            rdata4 = prev_req ? {16'h0100 + 16'(2 * prev_addr + 1), 16'h0100 + 16'(2 * prev_addr)} : 32'h0;
            prev_req  = req_valid4;
            prev_addr = req_addr4;
            if (req_valid4) begin
                if (req_addr4 >= 18'd4) bad_addr++;
                nreq++;
            end
            if (pix_valid4) begin
                chk($sformatf("t3_pixel%0d", npix), 32'(pix4), 32'h0100 + 32'(npix));
                npix++;
            end
            if (npix >= 8 && !busy4) break;
            @(negedge clk);
            cyc++;
        end
        rv4 = 0; rdata4 = '0;
        chk("t3_within_budget", 32'(cyc < 60), 32'd1);
        chk("t3_request_count", 32'(nreq), 32'd4);
        chk("t3_bad_addr", 32'(bad_addr), 32'd0);
        chk("t3_pixel_count", 32'(npix), 32'd8);
        chk("t3_busy_idle", 32'(busy4), 32'd0);
        repeat (2) @(negedge clk);
        chk("t3_idle_reqValid", 32'(req_valid4), 32'd0);
        chk("t3_idle_pixelValid", 32'(pix_valid4), 32'd0);
        chk("t3_overflowErr", 32'(oe4), 32'd0);
        pr4 = 0; rr4 = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ddr_pixel_fetch.md
Name: ddr_pixel_fetch

Overview:
Read-side front end that sits directly upstream of the DDR controller and feeds VGA scan-out.
- Generates sequential 32-bit word read requests for one frame buffer and hands them to the controller.
- Buffers the returned read data in an internal FIFO.
- Unpacks each word into two 16-bit pixels for the scan-out consumer.
- Credit-based flow control guarantees read returns never overflow the FIFO.

Parameters:
FIFO_DEPTH, 16, FIFO depth in 32-bit words (power of two, 4..64)
ADDR_W, 18, width of word address
FRAME_WORDS, 153600, words per frame (640x480 x 16 bit / 32)
BASE_ADDR, 0, word address of pixel 0

Ports:
clk133_p  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
frameStart  in  1  single-cycle pulse: begin (or restart) fetching a frame at BASE_ADDR
reqValid  out  1  read request valid toward DDR controller
reqAddr  out  ADDR_W  word address of request
reqReady  in  1  controller accepts request this cycle (transfer = reqValid & reqReady)
rdValid  in  1  one returned word valid this cycle; returns in request order
rdData  in  32  returned word; [15:0] = first pixel, [31:16] = second pixel
pixelValid  out  1  pixel available
pixel  out  16  current pixel
pixelReady  in  1  consumer takes pixel this cycle (transfer = pixelValid & pixelReady)
busy  out  1  frame in progress (state != IDLE)
overflowErr  out  1  sticky: rdValid seen with FIFO full
underflowErr  out  1  sticky: pixelReady high while pixelValid low in FETCH/DRAIN

Behaviour:
- Reset values:
  - state = IDLE; reqValid = 0; reqAddr = BASE_ADDR; pixelValid = 0; pixel = 0; busy = 0; both error flags = 0.
  - Counters zero; FIFO empty; half-select = low.
- States: IDLE -> FETCH on frameStart. FETCH -> DRAIN when the request count reaches FRAME_WORDS. DRAIN -> IDLE when outstanding = 0, FIFO empty and the last pixel has been consumed.
- Credit rule:
  - reqValid = (state == FETCH) & (outstanding + fifoCount < FIFO_DEPTH).
  - outstanding increments on request transfer and decrements on rdValid; both in the same cycle leaves it unchanged.
- reqAddr is held while reqValid & !reqReady. It increments by 1 after each transfer; the address after the last request is never presented.
- FIFO: write on rdValid (unless discarding), pop when the high half of the head word is transferred. Write and pop in the same cycle with the FIFO full is legal.
- Unpack:
  - pixel = head word [15:0] when half = 0, [31:16] when half = 1.
  - half toggles on each pixel transfer.
  - pixelValid = FIFO not empty (combinational from the FIFO head, no extra latency).
- Latency: rdValid at cycle N gives pixelValid = 1 at cycle N+1 when the FIFO was empty.
- frameStart outside IDLE (abort/restart):
  - discard counter loads the current outstanding count, minus any rdValid in the same cycle.
  - FIFO flushed; half = 0; reqAddr = BASE_ADDR; request count = 0; state = FETCH.
  - The next discard-count rdValid words are dropped and not written.
  - reqValid stays 0 until the discard count reaches 0, so stale data never mixes with the new frame.
- Boundaries:
  - rdValid with FIFO full and no pop: word dropped, overflowErr set.
  - rdValid with outstanding = 0: ignored, overflowErr set.
  - Error flags clear only on rst.
- rst mid-frame: everything returns to reset values immediately (asynchronous). The controller is reset by the same signal.

Optional Feature:
UNDERFLOW_HOLD_EN.
- Defined: during FETCH/DRAIN, when the FIFO is empty, pixelValid is 1 and pixel repeats the last transferred pixel (0 if none yet), so scan-out holds a pixel instead of stalling. A transfer in this condition sets underflowErr and does not advance half.
- Undefined: pixelValid = 0 when empty, as described under Behaviour.

Decomposition:
- Shared package: state encodings (IDLE/FETCH/DRAIN), FRAME_WORDS, BASE_ADDR and ADDR_W defaults. The display timing package reuses the frame geometry.
- One sub-module: ddr_word_fifo, a synchronous single-clock FIFO with count output, flush input, and first-word-fall-through read.
- ddr_pixel_fetch owns the FSM, credits, discard counter and unpacker.

Test Plan:
1. rst, then frameStart, reqReady = 1, no returns -> exactly 16 requests, addresses 0..15; reqValid then 0 while outstanding = 16.
2. Return 0x22221111 one cycle after the first request -> next cycle pixel = 0x1111 valid; after one transfer, pixel = 0x2222; after a second transfer, pop, and the credit frees one request (address 16).
3. FRAME_WORDS = 4, returns in order, pixelReady = 1 -> 8 pixels delivered in order, then DRAIN -> IDLE and busy = 0; no request with address 4.
4. Abort: 5 outstanding, frameStart pulse -> next 5 rdValid words dropped (no pixelValid), then requests restart at address 0; the first pixel delivered is from the new frame.
5. Inject rdValid with outstanding = 0 -> overflowErr = 1 and stays set until rst; the FIFO count does not change.
6. Consumer pixelReady = 1 with the FIFO empty in FETCH -> underflowErr = 1. With UNDERFLOW_HOLD_EN, the last pixel (e.g. 0x2222) is repeated with pixelValid = 1.
